// File: rtl/gray_arb_pkg.sv
// Shared types, default sizes and step-legality helper for the Gray decode arbiter.
package gray_arb_pkg;

  localparam int unsigned N_DEF    = 8;
  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned IDW_DEF  = $clog2(NREQ_DEF);
  // Widest word the step checker handles; words are zero-extended to this.
  localparam int unsigned STEP_W   = 32;

  typedef struct packed {
    logic [N_DEF-1:0]   bin;
    logic [IDW_DEF-1:0] id;
    logic               err;
  } out_rec_t;

  // Legal when unseen, or the modulo-2^w distance from last is 0, +1 or -1.
  function automatic logic step_legal(input logic [STEP_W-1:0] bin,
                                      input logic [STEP_W-1:0] last,
                                      input logic              seen,
                                      input int unsigned       w);
    logic [STEP_W-1:0] mask;
    logic [STEP_W-1:0] d;
    mask = (w >= STEP_W) ? '1 : ((STEP_W'(1) << w) - STEP_W'(1));
    d    = (bin - last) & mask;
    return !seen || (d == '0) || (d == STEP_W'(1)) || (d == mask);
  endfunction

endpackage

// File: rtl/gray_decode_arbiter_g2b.sv
// Combinational N-bit Gray-to-binary converter.
module gray_decode_arbiter_g2b #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter sharing one Gray decoder, with per-requester step checking.
module gray_decode_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int unsigned N    = N_DEF,
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_gray,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_bin,
  output logic [IDW-1:0]    out_id,
  output logic              out_step_err,
  output logic              err_sticky,
  input  logic              err_clr
);

  typedef struct packed {
    logic [N-1:0]   bin;
    logic [IDW-1:0] id;
    logic           err;
  } rec_t;

  rec_t            out_q;
  logic [IDW-1:0]  ptr_q;
  logic [N-1:0]    last_q [NREQ];
  logic [NREQ-1:0] seen_q;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic            slot_free;
  logic            xfer;
  logic [N-1:0]    gray_sel;
  logic [N-1:0]    bin_c;
  logic            step_err_c;
  int unsigned     idx;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign xfer      = rst_n && gnt_found && slot_free;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  assign gray_sel = req_gray[32'(gnt_id) * N +: N];

  gray_decode_arbiter_g2b #(.N(N)) u_g2b (
    .gray (gray_sel),
    .bin  (bin_c)
  );

  assign step_err_c = !step_legal(STEP_W'(bin_c), STEP_W'(last_q[gnt_id]),
                                  seen_q[gnt_id], N);

  // Output stage, pointer and per-requester history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      ptr_q      <= '0;
      seen_q     <= '0;
      err_sticky <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) last_q[i] <= '0;
    end else begin
      if (xfer) begin
        out_valid      <= 1'b1;
        out_q.bin      <= bin_c;
        out_q.id       <= gnt_id;
        out_q.err      <= step_err_c;
        ptr_q          <= IDW'((32'(gnt_id) + 1) % NREQ);
        last_q[gnt_id] <= bin_c;
        seen_q[gnt_id] <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A draining error word takes priority over a clear in the same cycle.
      if (out_valid && out_ready && out_q.err) err_sticky <= 1'b1;
      else if (err_clr)                        err_sticky <= 1'b0;
    end
  end

  assign out_bin      = out_q.bin;
  assign out_id       = out_q.id;
  assign out_step_err = out_q.err;

endmodule
